// File: rtl/lsu_axil_master.sv
// lsu_axil_master: single-outstanding load/store to AXI-lite bridge (optional LSU_MISALIGN_CHECK_EN traps misaligned accesses)
module lsu_axil_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;
  state_t state, state_n;
  logic        wen_q, uns_q, aw_done, w_done, accept, misalign, aw_hs, w_hs;
  logic [31:0] addr_q, wdata_q, sh, ext;
  logic [1:0]  size_q;
  logic [3:0]  strb;
  assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign req_ready  = state == IDLE && !rst;
  assign arvalid    = state == RD_ADDR;
  assign rready     = state == RD_DATA;
  assign awvalid    = state == WR_REQ && !aw_done;
  assign wvalid     = state == WR_REQ && !w_done;
  assign bready     = state == WR_RESP;
  assign resp_valid = state == RESP;
  assign araddr     = {addr_q[31:2], 2'b00};
  assign awaddr     = {addr_q[31:2], 2'b00};
  assign wdata      = wdata_q << {addr_q[1:0], 3'b000};
  assign strb       = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
  assign wstrb      = strb << addr_q[1:0];
  assign sh         = rdata >> {addr_q[1:0], 3'b000};
  assign ext        = size_q == 2'd0 ? {{24{!uns_q && sh[7]}}, sh[7:0]} :
                      size_q == 2'd1 ? {{16{!uns_q && sh[15]}}, sh[15:0]} : sh;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state: one bus transaction per request, response held until taken
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = misalign ? RESP : req_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) state_n = RD_DATA;
      RD_DATA: if (rvalid) state_n = RESP;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
      WR_RESP: if (bvalid) state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // request capture, write-channel bookkeeping and response formation
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q      <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q      <= req_wen;
        uns_q      <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= misalign;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (rready && rvalid) begin
        resp_rdata <= rresp != 2'd0 ? 32'd0 : ext;
        resp_err   <= rresp != 2'd0;
      end
      if (bready && bvalid) resp_err <= bresp != 2'd0;
    end
  end
endmodule

// File: tb/tb_lsu_axil_master.sv
// tb_lsu_axil_master: directed self-checking bench for lsu_axil_master
module tb_lsu_axil_master;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata, araddr, awaddr, wdata;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic [3:0]  wstrb;
  int checks = 0, failures = 0;

  lsu_axil_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic load_txn(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] d, input logic [1:0] rr, output logic [31:0] ar,
                          output int ar_cyc, output int rsp_cyc, output logic [31:0] rd,
                          output logic er, output logic rdy_in_resp);
    logic hs;
    ar = '0; ar_cyc = -1; rsp_cyc = -1; rd = '0; er = 1'b0; rdy_in_resp = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a; req_size = sz; req_unsigned = u;
    req_wdata = '0; arready = 1'b1;
    for (int c = 1; c <= 20 && rsp_cyc < 0; c++) begin
      hs = arvalid && arready;
      @(posedge clk); #1;
      req_valid = 1'b0; rvalid = hs; rdata = hs ? d : 32'd0; rresp = hs ? rr : 2'd0;
      if (arvalid && ar_cyc < 0) begin ar_cyc = c; ar = araddr; end
      if (resp_valid) begin rsp_cyc = c; rd = resp_rdata; er = resp_err; rdy_in_resp = req_ready; end
    end
    arready = 1'b0; rvalid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic store_txn(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                           input logic [1:0] br, input int awd, input int wdl,
                           output logic [31:0] aw_a, output logic [31:0] wd_o, output logic [3:0] st_o,
                           output int rsp_cyc, output logic [31:0] rd, output logic er,
                           output int awc, output int wc, output int bc, output logic skew);
    logic aw_h, w_h, b_h;
    aw_a = '0; wd_o = '0; st_o = '0; rsp_cyc = -1; rd = '0; er = 1'b0;
    awc = 0; wc = 0; bc = 0; skew = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_size = sz; req_wdata = d; req_unsigned = 1'b0;
    for (int c = 1; c <= 20 && rsp_cyc < 0; c++) begin
      aw_h = awvalid && awready; w_h = wvalid && wready; b_h = bvalid && bready;
      awc += int'(aw_h); wc += int'(w_h); bc += int'(b_h);
      @(posedge clk); #1;
      req_valid = 1'b0; awready = c >= 1 + awd; wready = c >= 1 + wdl;
      bvalid = awc > 0 && wc > 0 && bc == 0; bresp = br;
      if (c == 1) begin aw_a = awaddr; wd_o = wdata; st_o = wstrb; end
      if (awvalid && !wvalid) skew = 1'b1;
      if (resp_valid) begin rsp_cyc = c; rd = resp_rdata; er = resp_err; end
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({resp_valid, resp_err, arvalid, awvalid, wvalid, rready, bready, req_ready} !== 8'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000000", {resp_valid, resp_err, arvalid, awvalid, wvalid, rready, bready, req_ready}); end
    checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load;
    logic [31:0] ar, rd; int ac, rc; logic er, rr;
    load_txn(32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (ar !== 32'h8000_0004) begin failures++; $display("FAIL wl_araddr got=%h exp=80000004", ar); end
    checks++; if (ac !== 1) begin failures++; $display("FAIL wl_ar_cycle got=%0d exp=1", ac); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL wl_resp_cycle got=%0d exp=3", rc); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wl_rdata got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wl_err got=%b exp=0", er); end
  endtask

  task automatic test_sub_word_load;
    logic [31:0] ar, rd; int ac, rc; logic er, rr;
    load_txn(32'h8000_0003, 2'd0, 1'b0, 32'h8012_3456, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", rd); end
    checks++; if (ar !== 32'h8000_0000) begin failures++; $display("FAIL lb_araddr got=%h exp=80000000", ar); end
    load_txn(32'h8000_0003, 2'd0, 1'b1, 32'h8012_3456, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=00000080", rd); end
    load_txn(32'h8000_0002, 2'd1, 1'b0, 32'h8001_0000, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8001", rd); end
    load_txn(32'h8000_0000, 2'd1, 1'b1, 32'h1234_F00D, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (rd !== 32'h0000_F00D) begin failures++; $display("FAIL lhu got=%h exp=0000f00d", rd); end
  endtask

  task automatic test_read_error;
    logic [31:0] ar, rd; int ac, rc; logic er, rr;
    load_txn(32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 2'd2, ar, ac, rc, rd, er, rr);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL rd_err_flag got=%b exp=1", er); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rd_err_data got=%h exp=0", rd); end
  endtask

  task automatic test_half_store;
    logic [31:0] aa, wd, rd; logic [3:0] st; int rc, awc, wc, bc; logic er, sk;
    store_txn(32'h8000_0002, 2'd1, 32'h0000_ABCD, 2'd0, 0, 0, aa, wd, st, rc, rd, er, awc, wc, bc, sk);
    checks++; if (aa !== 32'h8000_0000) begin failures++; $display("FAIL sh_awaddr got=%h exp=80000000", aa); end
    checks++; if (wd !== 32'hABCD_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd0000", wd); end
    checks++; if (st !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", st); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL sh_resp_cycle got=%0d exp=3", rc); end
    checks++; if ({er, rd} !== 33'd0) begin failures++; $display("FAIL sh_resp got=%b/%h exp=0/0", er, rd); end
    store_txn(32'h8000_0001, 2'd0, 32'h1234_5678, 2'd0, 0, 0, aa, wd, st, rc, rd, er, awc, wc, bc, sk);
    checks++; if (wd !== 32'h3456_7800) begin failures++; $display("FAIL sb_wdata got=%h exp=34567800", wd); end
    checks++; if (st !== 4'b0010) begin failures++; $display("FAIL sb_wstrb got=%b exp=0010", st); end
    store_txn(32'h8000_0010, 2'd2, 32'h0BAD_F00D, 2'd3, 0, 0, aa, wd, st, rc, rd, er, awc, wc, bc, sk);
    checks++; if (st !== 4'b1111) begin failures++; $display("FAIL sw_wstrb got=%b exp=1111", st); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL sw_berr got=%b exp=1", er); end
  endtask

  task automatic test_write_skew;
    logic [31:0] aa, wd, rd; logic [3:0] st; int rc, awc, wc, bc; logic er, sk;
    store_txn(32'h8000_0020, 2'd2, 32'hCAFE_F00D, 2'd0, 2, 0, aa, wd, st, rc, rd, er, awc, wc, bc, sk);
    checks++; if (sk !== 1'b1) begin failures++; $display("FAIL skew_w_drops got=%b exp=1", sk); end
    checks++; if ({awc, wc, bc} !== {32'd1, 32'd1, 32'd1}) begin failures++; $display("FAIL skew_hs_counts got=%0d/%0d/%0d exp=1/1/1", awc, wc, bc); end
    checks++; if (rc !== 5) begin failures++; $display("FAIL skew_resp_cycle got=%0d exp=5", rc); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL skew_resp_once got=%b exp=0", resp_valid); end
  endtask

  task automatic test_misalign;
    logic [31:0] ar, rd; int ac, rc; logic er, rr;
    load_txn(32'h8000_0001, 2'd2, 1'b0, 32'h1122_3344, 2'd0, ar, ac, rc, rd, er, rr);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++; if (ac !== -1) begin failures++; $display("FAIL mis_no_ar got=%0d exp=-1", ac); end
    checks++; if (rc !== 1) begin failures++; $display("FAIL mis_resp_cycle got=%0d exp=1", rc); end
    checks++; if ({er, rd} !== {1'b1, 32'd0}) begin failures++; $display("FAIL mis_resp got=%b/%h exp=1/0", er, rd); end
`else
    checks++; if (ar !== 32'h8000_0000) begin failures++; $display("FAIL mis_araddr got=%h exp=80000000", ar); end
    checks++; if (rd !== 32'h0011_2233) begin failures++; $display("FAIL mis_rdata got=%h exp=00112233", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", er); end
    begin
      logic [31:0] aa, wd; logic [3:0] st; int src, awc, wc, bc; logic ser, sk;
      store_txn(32'h8000_0003, 2'd1, 32'h0000_ABCD, 2'd0, 0, 0, aa, wd, st, src, rd, ser, awc, wc, bc, sk);
      checks++; if (st !== 4'b1000) begin failures++; $display("FAIL mis_st_wstrb got=%b exp=1000", st); end
      checks++; if (wd !== 32'hCD00_0000) begin failures++; $display("FAIL mis_st_wdata got=%h exp=cd000000", wd); end
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] ar, rd; int ac, rc; logic er, rr;
    load_txn(32'h8000_0004, 2'd2, 1'b0, 32'h0000_0001, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (rr !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_resp got=%b exp=0", rr); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after got=%b exp=1", req_ready); end
    load_txn(32'h8000_0008, 2'd2, 1'b0, 32'h0000_0002, 2'd0, ar, ac, rc, rd, er, rr);
    checks++; if (rc !== 3 || rd !== 32'd2) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=3/00000002", rc, rd); end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0004; req_size = 2'd2; arready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rmid_in_rd_data got=%b exp=1", rready); end
    rst = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    checks++; if ({arvalid, rready, resp_valid, req_ready} !== 4'b0) begin
      failures++; $display("FAIL rmid_outputs got=%b exp=0000", {arvalid, rready, resp_valid, req_ready}); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_resp got=%b exp=0", resp_valid); end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_sub_word_load;
    test_read_error;
    test_half_store;
    test_write_skew;
    test_misalign;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_axil_master.md
# lsu_axil_master

Load/store unit bus front-end. It sits between the core's memory stage and the AXI-lite data memory slave. It accepts one load or store request at a time and drives the corresponding AXI-lite read or write transaction. It aligns write data and byte strobes to the 32-bit bus, then extracts and extends load data before returning a single response to the core.

## Interface
- Parameters: none; address and data paths are fixed at 32 bits.
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  1 only in IDLE and not in reset.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- resp_valid  out  1  response valid, held until resp_ready.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  bus error (resp != 0) or misalignment.
- araddr / arvalid / arready: out 32 / out 1 / in 1.
- rdata / rresp / rvalid / rready: in 32 / in 2 / in 1 / out 1.
- awaddr / awvalid / awready: out 32 / out 1 / in 1.
- wdata / wstrb / wvalid / wready: out 32 / out 4 / out 1 / in 1.
- bresp / bvalid / bready: in 2 / in 1 / out 1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- Request capture: in IDLE, req_valid&&req_ready latches wen, addr, wdata, size and unsigned. The block then moves to RD_ADDR (load) or WR_REQ (store).
- Bus address: araddr and awaddr are {addr[31:2],2'b00}, driven from the latched address.
- RD_ADDR: arvalid=1 until arready; then RD_DATA.
- RD_DATA: rready=1. On rvalid, the block shifts rdata right by 8*addr[1:0] and keeps the low 8/16/32 bits per size. It then zero-extends or sign-extends, sets resp_err=(rresp!=0), and moves to RESP.
- WR_REQ: wdata = wdata_latched << 8*addr[1:0]. wstrb = (0001 / 0011 / 1111 per size) << addr[1:0], truncated to 4 bits.
- WR_REQ handshakes: awvalid and wvalid are both raised on entry. Each drops independently after its own handshake, tracked by aw_done and w_done flags.
- WR_REQ exit: moves to WR_RESP in the cycle the last of the two handshakes completes. Both handshakes may complete in the same cycle.
- WR_RESP: bready=1. On bvalid, resp_err=(bresp!=0) and the block moves to RESP.
- RESP: resp_valid=1 with rdata and err stable. On resp_ready the block returns to IDLE. The next request can be accepted one cycle later, not in the same cycle.
- Unaligned bytes that fall past lane 3 are dropped: no split transaction is issued. Missing read bytes are taken as 0 before extension.
- Only one transaction is ever outstanding. AR, AW and W are never asserted in RESP or IDLE.

## Timing
- Reset values: resp_valid=0, resp_err=0, resp_rdata=0, arvalid=0, awvalid=0, wvalid=0, rready=0, bready=0, req_ready=0, state=IDLE.
- Reset mid-transaction: the transaction is abandoned and the next cycle is IDLE. No response is produced.
- Every valid and ready output is a registered-state decode with no combinational path from an input to a valid.
- Load latency against a zero-wait slave (arready=1, rvalid the cycle after the AR handshake):
  - request accepted at cycle 0;
  - arvalid at cycle 1;
  - rvalid sampled at cycle 2;
  - resp_valid at cycle 3.
- Store latency: aw and w handshakes at cycle 1, bvalid at cycle 2, resp_valid at cycle 3.
- Each added slave wait cycle adds exactly one cycle. Back-to-back throughput is one access per 4 cycles minimum.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: a misaligned request skips the bus entirely and goes directly to RESP on the next cycle with resp_err=1 and resp_rdata=0. Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- LSU_MISALIGN_CHECK_EN undefined: a misaligned request is issued with the truncation rules above and resp_err reflects only the bus response.

## Test plan
- Word load from addr 0x80000004, slave returns 0xDEADBEEF -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at cycle 3.
- Byte load from 0x80000003, signed, rdata=0x80123456 -> resp_rdata=0xFFFFFF80. The same load unsigned -> 0x00000080.
- Half store of 0x0000ABCD to 0x80000002 -> awaddr=0x80000000, wdata=0xABCD0000, wstrb=1100.
- Slave asserts wready two cycles before awready -> wvalid drops after the W handshake, awvalid holds, exactly one B handshake, resp_valid once.
- Word load to 0x80000001 -> with LSU_MISALIGN_CHECK_EN: no arvalid, resp_err=1 one cycle later. Without the macro: araddr=0x80000000 and the result is rdata>>8.
- rst asserted while in RD_DATA -> next cycle arvalid=0, rready=0, resp_valid=0, and req_ready=1 once rst drops.
